adc_200mhz_gen: RTL and testbench

//   Synthetic 14-bit ADC sample source for the 200 MHz acquisition domain.

---
 rtl/adc_200mhz_gen.sv | 105 ++++++++++
 tb/tb_adc_200mhz_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_200mhz_gen.sv
// Synthetic 14-bit ADC source (MODE 0 sine NCO, 1 ramp, 2 LFSR); 2-register latency, free-running, no backpressure.
// Define ADC_GEN_NOISE_EN to add saturated LFSR noise in the output stage.
module adc_200mhz_gen #(
  parameter int          MODE      = 0,
  parameter int          PHASE_W   = 32,
  parameter int unsigned PHASE_INC = 214748365,
  parameter int          LUT_AW    = 8,
  parameter int          RAMP_STEP = 1,
  parameter int          NOISE_W   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [13:0] data_o
);

  localparam int                 LUT_N     = 2 ** LUT_AW;
  localparam logic [PHASE_W-1:0] INC       = PHASE_W'(PHASE_INC);
  localparam logic [13:0]        STEP      = 14'(RAMP_STEP);
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;

  // Quarter-wave table entry, evaluated at elaboration with a Taylor series.
  function automatic logic [12:0] rom_val(input int i);
    real x, x2, term, s;
    x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(LUT_N);
    x2   = x * x;
    term = x;
    s    = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x2 / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    return 13'($rtoi(8191.0 * s + 0.5));
  endfunction

  logic [12:0] rom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_rom
    assign rom[g] = rom_val(g);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [13:0]        ramp_q, ramp_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [13:0]        stage_q, stage_d;
  logic [13:0]        data_q, data_d;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  lut_addr;
  logic [13:0]        mag;

  always_comb begin
    acc_d  = acc_q + INC;
    ramp_d = ramp_q + STEP;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Odd quadrants walk the table backwards; upper half-cycle is negated.
  assign quad     = acc_q[PHASE_W-1 -: 2];
  assign lut_addr = quad[0] ? ~acc_q[PHASE_W-3 -: LUT_AW] : acc_q[PHASE_W-3 -: LUT_AW];
  assign mag      = {1'b0, rom[lut_addr]};

  always_comb begin
    case (MODE)
      0:       stage_d = quad[1] ? (~mag + 14'd1) : mag;
      1:       stage_d = ramp_q;
      2:       stage_d = lfsr_q[15:2];
      default: stage_d = '0;
    endcase
  end

`ifdef ADC_GEN_NOISE_EN
  logic signed [14:0] noisy;

  always_comb begin
    noisy = $signed({stage_q[13], stage_q}) + 15'($signed(lfsr_q[NOISE_W-1:0]));
    if (noisy > 15'sd8191) begin
      data_d = 14'h1FFF;
    end else if (noisy < -15'sd8192) begin
      data_d = 14'h2000;
    end else begin
      data_d = noisy[13:0];
    end
  end
`else
  assign data_d = stage_q;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc_q   <= '0;
      ramp_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      stage_q <= '0;
      data_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      ramp_q  <= ramp_d;
      lfsr_q  <= lfsr_d;
      stage_q <= stage_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_adc_200mhz_gen.sv
// Directed bench for adc_200mhz_gen: one instance per MODE sharing clock and reset.
`timescale 1ns/1ps
module tb_adc_200mhz_gen;

  localparam logic [31:0] INC = 32'd214748365;

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b0;
  logic [13:0] d_sine, d_ramp, d_lfsr, d_bad;
  int          checks  = 0;
  int          errors  = 0;

  always #2.5 clk_i = ~clk_i;

  adc_200mhz_gen #(.MODE(0)) u_sine (.clk_i(clk_i), .reset_i(reset_i), .data_o(d_sine));
  adc_200mhz_gen #(.MODE(1)) u_ramp (.clk_i(clk_i), .reset_i(reset_i), .data_o(d_ramp));
  adc_200mhz_gen #(.MODE(2)) u_lfsr (.clk_i(clk_i), .reset_i(reset_i), .data_o(d_lfsr));
  adc_200mhz_gen #(.MODE(3)) u_bad  (.clk_i(clk_i), .reset_i(reset_i), .data_o(d_bad));

  function automatic int sx(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sine_ref(input logic [31:0] acc);
    logic [1:0] q;
    logic [7:0] a;
    int         m;
    q = acc[31:30];
    a = acc[29:22];
    if (q[0]) a = ~a;
    m = $rtoi(8191.0 * $sin(3.14159265358979 * (real'(a) + 0.5) / 512.0) + 0.5);
    return q[1] ? -m : m;
  endfunction

  function automatic int ramp_ref(input int n);
    int v;
    v = (n < 2) ? 0 : ((n - 2) & 16383);
    return (v >= 8192) ? v - 16384 : v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  // Samples after edges 1..3 following a release; shared by power-on and mid-run reset.
  task automatic check_restart(input string tag);
    @(negedge clk_i);
    checks++;
    if (d_sine !== 14'd0 || d_ramp !== 14'd0 || d_lfsr !== 14'd0) begin
      errors++;
      $display("FAIL %s_edge1: sine=%0d ramp=%0d lfsr=%h, required all 0", tag, sx(d_sine), sx(d_ramp), d_lfsr);
    end
    @(negedge clk_i);
    checks++;
    if (sx(d_sine) !== 25) begin
      errors++;
      $display("FAIL %s_edge2_sine: got %0d, required 25", tag, sx(d_sine));
    end
    checks++;
    if (sx(d_ramp) !== 0) begin
      errors++;
      $display("FAIL %s_edge2_ramp: got %0d, required 0", tag, sx(d_ramp));
    end
    checks++;
    if (d_lfsr !== 14'h2B38) begin
      errors++;
      $display("FAIL %s_edge2_lfsr: got %h, required 2b38", tag, d_lfsr);
    end
    @(negedge clk_i);
    checks++;
    if (sx(d_sine) !== sine_ref(INC)) begin
      errors++;
      $display("FAIL %s_edge3_sine: got %0d, required %0d", tag, sx(d_sine), sine_ref(INC));
    end
    checks++;
    if (sx(d_ramp) !== 1) begin
      errors++;
      $display("FAIL %s_edge3_ramp: got %0d, required 1", tag, sx(d_ramp));
    end
    checks++;
    if (d_lfsr !== 14'h1670) begin
      errors++;
      $display("FAIL %s_edge3_lfsr: got %h, required 1670", tag, d_lfsr);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (d_sine !== 14'd0 || d_ramp !== 14'd0 || d_lfsr !== 14'd0 || d_bad !== 14'd0) begin
      errors++;
      $display("FAIL reset_hold: sine=%0d ramp=%0d lfsr=%h bad=%0d, required all 0",
               sx(d_sine), sx(d_ramp), d_lfsr, sx(d_bad));
    end
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    check_restart("reset");
  endtask

  task automatic test_sine();
    int          s [64];
    logic [31:0] acc;
    int          e, mx, mn;
    do_reset();
    acc = '0;
    mx  = -100000;
    mn  = 100000;
    for (int n = 1; n < 64; n++) begin
      @(negedge clk_i);
      s[n] = sx(d_sine);
      e    = (n == 1) ? 0 : sine_ref(acc);
      if (n >= 2) acc = acc + INC;
      if (s[n] > mx) mx = s[n];
      if (s[n] < mn) mn = s[n];
      checks++;
      if (s[n] !== e) begin
        errors++;
        $display("FAIL sine_sample[%0d]: got %0d, required %0d", n, s[n], e);
      end
    end
    for (int k = 2; k < 22; k++) begin
      checks++;
      if (s[k] !== s[k + 20]) begin
        errors++;
        $display("FAIL sine_period[%0d]: got %0d, required %0d", k + 20, s[k + 20], s[k]);
      end
    end
    for (int k = 2; k < 12; k++) begin
      checks++;
      if (s[k] + s[k + 10] > 1 || s[k] + s[k + 10] < -1) begin
        errors++;
        $display("FAIL sine_halfwave[%0d]: got %0d, required about %0d", k + 10, s[k + 10], -s[k]);
      end
    end
    checks++;
    if (s[7] !== 8191 || s[17] !== -8191 || s[12] !== -25) begin
      errors++;
      $display("FAIL sine_quadrants: got %0d/%0d/%0d, required 8191/-25/-8191", s[7], s[12], s[17]);
    end
    checks++;
    if (mx !== 8191 || mn !== -8191) begin
      errors++;
      $display("FAIL sine_peaks: got max %0d min %0d, required 8191 and -8191", mx, mn);
    end
  endtask

  task automatic test_ramp();
    int hi, lo, wrap;
    do_reset();
    hi = 0; lo = 0; wrap = -1;
    for (int n = 1; n <= 16386; n++) begin
      @(negedge clk_i);
      checks++;
      if (sx(d_ramp) !== ramp_ref(n)) begin
        errors++;
        $display("FAIL ramp_sample[%0d]: got %0d, required %0d", n, sx(d_ramp), ramp_ref(n));
      end
      if (n == 8193)  hi   = sx(d_ramp);
      if (n == 8194)  lo   = sx(d_ramp);
      if (n == 16386) wrap = sx(d_ramp);
    end
    checks++;
    if (hi !== 8191 || lo !== -8192) begin
      errors++;
      $display("FAIL ramp_signed_wrap: got %0d then %0d, required 8191 then -8192", hi, lo);
    end
    checks++;
    if (wrap !== 0) begin
      errors++;
      $display("FAIL ramp_full_wrap: got %0d, required 0", wrap);
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] st;
    logic [13:0] e;
    do_reset();
    st = 16'hACE1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      e = (n == 1) ? 14'd0 : st[15:2];
      if (n >= 2) st = lfsr_step(st);
      checks++;
      if (d_lfsr !== e) begin
        errors++;
        $display("FAIL lfsr_sample[%0d]: got %h, required %h", n, d_lfsr, e);
      end
    end
  endtask

  task automatic test_bad_mode();
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk_i);
      checks++;
      if (d_bad !== 14'd0) begin
        errors++;
        $display("FAIL bad_mode[%0d]: got %0d, required 0", n, sx(d_bad));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (7) @(negedge clk_i);
    #0.5 reset_i = 1'b0;
    #0.5;
    checks++;
    if (d_sine !== 14'd0 || d_ramp !== 14'd0 || d_lfsr !== 14'd0) begin
      errors++;
      $display("FAIL async_clear: sine=%0d ramp=%0d lfsr=%h, required all 0", sx(d_sine), sx(d_ramp), d_lfsr);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    check_restart("async");
  endtask

`ifdef ADC_GEN_NOISE_EN
  task automatic test_noise();
    int d, e, diff;
    do_reset();
    for (int n = 1; n <= 8300; n++) begin
      @(negedge clk_i);
      if (n >= 8150) begin
        d    = sx(d_ramp);
        e    = ramp_ref(n);
        diff = d - e;
        checks++;
        if (diff > 8 || diff < -8) begin
          errors++;
          $display("FAIL noise_bound[%0d]: got %0d, required within 8 of %0d", n, d, e);
        end
      end
    end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required test sequence to complete");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ADC_GEN_NOISE_EN
    #1;
    @(negedge clk_i);
    reset_i = 1'b1;
    test_noise();
`else
    test_reset();
    test_sine();
    test_ramp();
    test_lfsr();
    test_bad_mode();
    test_async_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
